// File: rtl/com_pkg.sv
// Shared definitions for the com_* serial blocks: receiver state encoding,
// oversampling constants and the baud divisor rounding helper.
package com_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int SAMPLE_TICK = 9;

  // round(clk_freq / (OVERSAMPLE * baud)), never below 1
  function automatic int div_round(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/com_uart_rx_if.sv
// Bus-side port bundle of the serial receiver: FIFO read port and error flags.
interface com_uart_rx_if #(
    parameter int FIFO_DEPTH_LOG = 4
);
    // rx_avail is the valid; rd_en is a pop that takes effect at the clock edge
    // only while rx_avail=1. rd_data shows the head byte whenever rx_avail=1 and
    // the next head appears the cycle after a pop.
    logic                    rd_en;
    logic [7:0]              rd_data;
    logic                    rx_avail;
    logic [FIFO_DEPTH_LOG:0] fifo_count;
    logic                    frame_err;
    logic                    overrun;
    logic                    err_clr;

    modport master (
        output rd_en, err_clr,
        input  rd_data, rx_avail, fifo_count, frame_err, overrun
    );

    modport slave (
        input  rd_en, err_clr,
        output rd_data, rx_avail, fifo_count, frame_err, overrun
    );
endinterface

// File: rtl/com_fifo.sv
// Synchronous show-ahead FIFO: rd_data is the head entry, count reports occupancy.
module com_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [DEPTH_LOG:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = rd_en && !empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/com_uart_rx.sv
// 16x-oversampled serial receiver feeding a show-ahead byte FIFO, 8N1 by default;
// defining UART_RX_PARITY_EN switches to 8E1 with a parity check.
module com_uart_rx
    import com_pkg::*;
#(
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD           = 115200,
    parameter int FIFO_DEPTH_LOG = 4
) (
    input  logic          clk50M,
    input  logic          rst,
    input  logic          com_RxD,
    com_uart_rx_if.slave  bus,
    output rx_state_e     state_dbg
);
    localparam int DIV = div_round(CLK_FREQ, BAUD);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_SAMPLE = TW'(SAMPLE_TICK);

    logic                    sync1, sync2, sync_prev;
    logic [1:0]              hist;
    logic                    fall, tick, sample_now, vote, stop_hit;
    logic [PW-1:0]           presc;
    logic [TW-1:0]           tick_cnt;
    logic [2:0]              bit_idx;
    logic [7:0]              shreg;
    rx_state_e               state;
    logic                    push, fe_set, ovr_set;
    logic                    frame_err, overrun;
    logic                    fifo_empty, fifo_full;
    logic [7:0]              fifo_rd_data;
    logic [FIFO_DEPTH_LOG:0] fifo_count;
`ifdef UART_RX_PARITY_EN
    logic                    par_bad;
`endif

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= com_RxD;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign fall       = sync_prev && !sync2;
    assign tick       = (presc == PRESC_LAST);
    assign sample_now = tick && (tick_cnt == TICK_SAMPLE);
    // hist holds the line at ticks 7 and 8; sync2 is tick 9 when sample_now fires
    assign vote       = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst)       hist <= 2'b11;
        else if (tick) hist <= {hist[0], sync2};
    end

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            if (tick) begin
                presc    <= '0;
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            end else begin
                presc    <= presc + 1'b1;
            end
            case (state)
                IDLE: if (fall) begin
                    state    <= START;
                    presc    <= '0;
                    tick_cnt <= '0;
                end
                START: if (sample_now) begin
                    state   <= vote ? IDLE : DATA;
                    bit_idx <= '0;
                end
                DATA: if (sample_now) begin
                    shreg   <= {vote, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (sample_now) begin
                    par_bad <= (vote != ^shreg);
                    state   <= STOP;
                end
`endif
                STOP: if (sample_now) begin
                    state   <= vote ? IDLE : BREAK;
`ifdef UART_RX_PARITY_EN
                    par_bad <= 1'b0;
`endif
                end
                BREAK: if (sync2) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stop_hit = (state == STOP) && sample_now;
`ifdef UART_RX_PARITY_EN
        push     = stop_hit && vote && !par_bad;
        fe_set   = stop_hit && (!vote || par_bad);
`else
        push     = stop_hit && vote;
        fe_set   = stop_hit && !vote;
`endif
        ovr_set  = push && fifo_full && !bus.rd_en;
    end

    // a new error in the same cycle as err_clr leaves the flag set
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= fe_set  ? 1'b1 : (bus.err_clr ? 1'b0 : frame_err);
            overrun   <= ovr_set ? 1'b1 : (bus.err_clr ? 1'b0 : overrun);
        end
    end

    com_fifo #(
        .WIDTH     (8),
        .DEPTH_LOG (FIFO_DEPTH_LOG)
    ) u_fifo (
        .clk     (clk50M),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (shreg),
        .rd_en   (bus.rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bus.rd_data    = fifo_rd_data;
    assign bus.rx_avail   = !fifo_empty;
    assign bus.fifo_count = fifo_count;
    assign bus.frame_err  = frame_err;
    assign bus.overrun    = overrun;
    assign state_dbg      = state;
endmodule

// File: tb/tb_com_uart_rx.sv
// Bench for com_uart_rx at 16 clocks per bit: directed corner cases, a vector
// table and randomized frames checked against a queue model of the FIFO and flags.
module tb_com_uart_rx;
  import com_pkg::*;

  localparam int CLK_FREQ = 16000000;
  localparam int BAUD     = 1000000;
  localparam int DL       = 4;
  localparam int DEPTH    = 1 << DL;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // edge (counted from the posedge the start bit follows) at which the stop bit
  // is voted: 3 edges of synchroniser/edge detect, 10 to tick 9, then 16 per bit
  localparam int STOP_EDGE = 3 + 10 + 16 * (FRAME_BITS - 1);

  logic      clk50M = 1'b0;
  logic      rst;
  logic      com_RxD;
  rx_state_e state_dbg;

  com_uart_rx_if #(.FIFO_DEPTH_LOG(DL)) bus();

  com_uart_rx #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD           (BAUD),
    .FIFO_DEPTH_LOG (DL)
  ) dut (
    .clk50M    (clk50M),
    .rst       (rst),
    .com_RxD   (com_RxD),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk50M = ~clk50M;

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         m_fe;
  bit         m_ovr;
  logic [7:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input bit good);
    if (!good)                    m_fe  = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else                          m_ovr = 1'b1;
  endtask

  task automatic check_state(input string name);
    chk({name, "_count"}, 32'(bus.fifo_count), 32'(exp_q.size()));
    chk({name, "_avail"}, 32'(bus.rx_avail), 32'(exp_q.size() != 0));
    chk({name, "_fe"}, 32'(bus.frame_err), 32'(m_fe));
    chk({name, "_ovr"}, 32'(bus.overrun), 32'(m_ovr));
    if (exp_q.size() != 0) chk({name, "_head"}, 32'(bus.rd_data), 32'(exp_q[0]));
  endtask

  // ---------------- drivers (called just after a posedge) ----------------
  task automatic drive_bit(input logic v);
    com_RxD = v;
    repeat (16) @(posedge clk50M);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk50M);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip);
    @(posedge clk50M);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) com_RxD = 1'b1;
`endif
    drive_bit(stop_bit);
    com_RxD = 1'b1;
    if (!stop_bit) idle(32);
  endtask

  task automatic pop_check(input string name);
    chk({name, "_avail"}, 32'(bus.rx_avail), 32'd1);
    chk({name, "_data"}, 32'(bus.rd_data), 32'(exp_q[0]));
    last_rd = bus.rd_data;
    void'(exp_q.pop_front());
    bus.rd_en = 1'b1;
    @(posedge clk50M);
    #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic pop_empty(input string name);
    bus.rd_en = 1'b1;
    @(posedge clk50M);
    #1;
    bus.rd_en = 1'b0;
    chk({name, "_count"}, 32'(bus.fifo_count), 32'd0);
    chk({name, "_data"}, 32'(bus.rd_data), 32'd0);
  endtask

  task automatic clear_errs();
    bus.err_clr = 1'b1;
    @(posedge clk50M);
    #1;
    bus.err_clr = 1'b0;
    m_fe  = 1'b0;
    m_ovr = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    bit         stop_bit;
    bit         clr_after;
    int         exp_count;
    bit         exp_fe;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] d;
    bit         good;
    int         npops;

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 0, 1'b1};
    vecs[1] = '{8'h55, 1'b1, 1'b1, 1, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 1, 1'b0};

    rst         = 1'b1;
    com_RxD     = 1'b1;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    m_fe        = 1'b0;
    m_ovr       = 1'b0;
    last_rd     = 8'h00;

    // reset state
    repeat (3) @(posedge clk50M);
    #1;
    chk("rst_rd_data", 32'(bus.rd_data), 32'h00);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    check_state("rst");
    rst = 1'b0;
    idle(20);

    // single byte, exact visibility cycle
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        @(posedge clk50M);
        repeat (STOP_EDGE - 1) @(posedge clk50M);
        #1;
        chk("t1_before_stop", 32'(bus.rx_avail), 32'd0);
        @(posedge clk50M);
        #1;
        chk("t1_after_avail", 32'(bus.rx_avail), 32'd1);
        chk("t1_after_data", 32'(bus.rd_data), 32'hA5);
        chk("t1_after_count", 32'(bus.fifo_count), 32'd1);
      end
    join
    model_frame(8'hA5, 1'b1);
    pop_check("t1_pop");
    check_state("t1_empty");

    // short low glitch on the idle line
    @(posedge clk50M);
    #1;
    com_RxD = 1'b0;
    repeat (3) @(posedge clk50M);
    #1;
    com_RxD = 1'b1;
    idle(40);
    chk("t2_state", 32'(state_dbg), 32'(IDLE));
    check_state("t2");

    // vector table: good and bad stop bits, sticky frame error, err_clr
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, 1'b0);
      model_frame(vecs[i].data, vecs[i].stop_bit);
      idle(2);
      chk($sformatf("vec%0d_count", i), 32'(bus.fifo_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_fe", i), 32'(bus.frame_err), 32'(vecs[i].exp_fe));
      chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(IDLE));
      if (vecs[i].exp_count != 0) begin
        chk($sformatf("vec%0d_head", i), 32'(bus.rd_data), 32'(vecs[i].data));
        pop_check($sformatf("vec%0d_pop", i));
      end
      if (vecs[i].clr_after) begin
        clear_errs();
        chk($sformatf("vec%0d_clr", i), 32'(bus.frame_err), 32'd0);
      end
    end

    // 17 bytes without reading: overflow drops the last one
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_frame(8'(i), 1'b1);
    end
    chk("t4_count", 32'(bus.fifo_count), 32'd16);
    chk("t4_ovr", 32'(bus.overrun), 32'd1);
    check_state("t4");
    while (exp_q.size() != 0) pop_check("t4_read");
    chk("t4_last", 32'(last_rd), 32'h0F);
    check_state("t4_drained");

    // full FIFO, pop in the push cycle of 0x99
    clear_errs();
    chk("t5_ovr_clr", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b1, 1'b0);
      model_frame(d, 1'b1);
    end
    check_state("t5_full");
    fork
      send_frame(8'h99, 1'b1, 1'b0);
      begin
        @(posedge clk50M);
        repeat (STOP_EDGE - 1) @(posedge clk50M);
        #1;
        chk("t5_head_at_push", 32'(bus.rd_data), 32'(exp_q[0]));
        bus.rd_en = 1'b1;
        @(posedge clk50M);
        #1;
        bus.rd_en = 1'b0;
        void'(exp_q.pop_front());
      end
    join
    exp_q.push_back(8'h99);
    chk("t5_count", 32'(bus.fifo_count), 32'd16);
    chk("t5_ovr", 32'(bus.overrun), 32'd0);
    check_state("t5");
    while (exp_q.size() != 0) pop_check("t5_read");
    chk("t5_last", 32'(last_rd), 32'h99);

    // reset in the middle of a frame
    send_frame(8'h11, 1'b1, 1'b0);
    model_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0);
    model_frame(8'h22, 1'b0);
    check_state("t6_pre");
    d = 8'h7E;
    @(posedge clk50M);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    com_RxD = d[4];
    repeat (8) @(posedge clk50M);
    #1;
    rst     = 1'b1;
    com_RxD = 1'b1;
    #1;
    exp_q.delete();
    m_fe  = 1'b0;
    m_ovr = 1'b0;
    chk("t6_rst_rd_data", 32'(bus.rd_data), 32'h00);
    chk("t6_rst_state", 32'(state_dbg), 32'(IDLE));
    check_state("t6_rst");
    repeat (3) @(posedge clk50M);
    #1;
    rst = 1'b0;
    idle(32);
    check_state("t6_after_rst");
`ifdef UART_RX_PARITY_EN
    send_frame(8'h7E, 1'b1, 1'b1);
    model_frame(8'h7E, 1'b0);
    idle(2);
    chk("t6_par_fe", 32'(bus.frame_err), 32'd1);
    check_state("t6_par");
    clear_errs();
`else
    send_frame(8'h7E, 1'b1, 1'b0);
    model_frame(8'h7E, 1'b1);
    idle(2);
    chk("t6_data", 32'(bus.rd_data), 32'h7E);
    check_state("t6_frame");
    pop_check("t6_pop");
`endif

    // randomized frames, reads and clears against the queue model
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 20));
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      send_frame(d, good, 1'b0);
      model_frame(d, good);
      idle(1);
      check_state($sformatf("rnd%0d", n));
      npops = $urandom_range(0, 3);
      for (int p = 0; p < npops; p++) begin
        if (exp_q.size() != 0) pop_check($sformatf("rnd%0d_pop", n));
        else                   pop_empty($sformatf("rnd%0d_pop_empty", n));
      end
      if ($urandom_range(0, 7) == 0) clear_errs();
      check_state($sformatf("rnd%0d_post", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
